// File: rtl/serial_tx_if.sv
// Bundle between the alarm-side requesters and the serial_tx_scheduler.
// Requester side (master) drives enable, request levels, messages and the
// stand-by count. Scheduler side (slave) returns the ACK pulse, the grant
// index and the line signals BUSY/SEND/OUT.
//   i_en       : enables new grants
//   i_req      : level request per requester
//   i_msg      : flattened messages, requester i at [i*MSG_W +: MSG_W]
//   i_sb       : stand-by count, gap lasts i_sb+1 cycles
//   o_ack      : one-cycle one-hot pulse, message i latched
//   o_grant_id : index of the current/last granted requester
//   o_busy     : frame in progress
//   o_send     : frame-start strobe
//   o_out      : serial data, LSB first
interface serial_tx_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned MSG_W = 4,
   parameter int unsigned SB_W  = 4
);
   localparam int unsigned GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic                     i_en;
   logic [N_REQ-1:0]         i_req;
   logic [N_REQ*MSG_W-1:0]   i_msg;
   logic [SB_W-1:0]          i_sb;
   logic [N_REQ-1:0]         o_ack;
   logic [GRANT_W-1:0]       o_grant_id;
   logic                     o_busy;
   logic                     o_send;
   logic                     o_out;

   modport master (
      output i_en, i_req, i_msg, i_sb,
      input  o_ack, o_grant_id, o_busy, o_send, o_out
   );

   modport slave (
      input  i_en, i_req, i_msg, i_sb,
      output o_ack, o_grant_id, o_busy, o_send, o_out
   );
endinterface

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one serial status channel between N_REQ
// requesters. A grant latches the winner's message and stand-by count, then
// the frame goes out as: one SEND strobe cycle, MSG_W data bits LSB first,
// and a stand-by gap of SB+1 cycles before returning to IDLE.
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : synchronous active-high reset, aborts any frame immediately
//   bus   : serial_tx_if slave modport (EN/REQ/MSG/SB in, ACK/GRANT_ID/
//           BUSY/SEND/OUT out); all outputs are registered
module serial_tx_scheduler #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned MSG_W = 4,
   parameter int unsigned SB_W  = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   serial_tx_if.slave   bus
);
   localparam int unsigned GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned BIT_W   = (MSG_W > 1) ? $clog2(MSG_W) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(MSG_W - 1);
   localparam logic [GRANT_W-1:0] RR_INIT  = GRANT_W'(N_REQ - 1);

   // state and registered outputs
   logic [1:0]          r_state;
   logic [N_REQ-1:0]    r_ack;
   logic [GRANT_W-1:0]  r_grant_id;
   logic                r_busy;
   logic                r_send;
   logic                r_out;
   logic [MSG_W-1:0]    r_msg;
   logic [SB_W-1:0]     r_sb;
   logic [GRANT_W-1:0]  r_rr;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic [SB_W-1:0]     r_gap_cnt;

   // next-state values
   logic [1:0]          w_state;
   logic [N_REQ-1:0]    w_ack;
   logic [GRANT_W-1:0]  w_grant_id;
   logic                w_busy;
   logic                w_send;
   logic                w_out;
   logic [MSG_W-1:0]    w_msg;
   logic [SB_W-1:0]     w_sb;
   logic [GRANT_W-1:0]  w_rr;
   logic [BIT_W-1:0]    w_bit_cnt;
   logic [SB_W-1:0]     w_gap_cnt;

   // arbitration helpers
   logic                w_found;
   logic [GRANT_W-1:0]  w_winner;
   logic [GRANT_W-1:0]  w_cand;
   logic [MSG_W-1:0]    w_msg_sel;

   // Round-robin pick: first set request scanning upward from r_rr+1.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         w_cand = GRANT_W'((32'(r_rr) + k) % N_REQ);
         if (!w_found && bus.i_req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // Message of the winning requester.
   always_comb begin
      w_msg_sel = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_winner == GRANT_W'(k)) begin
            w_msg_sel = bus.i_msg[k*MSG_W +: MSG_W];
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state    = r_state;
      w_ack      = '0;
      w_grant_id = r_grant_id;
      w_busy     = r_busy;
      w_send     = 1'b0;
      w_out      = 1'b0;
      w_msg      = r_msg;
      w_sb       = r_sb;
      w_rr       = r_rr;
      w_bit_cnt  = r_bit_cnt;
      w_gap_cnt  = r_gap_cnt;

      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.i_en && w_found) begin
               // Message and stand-by count are both captured here, so the
               // whole frame is fixed once granted.
               w_state    = S_START;
               w_ack      = N_REQ'(1) << w_winner;
               w_grant_id = w_winner;
               w_rr       = w_winner;
               w_msg      = w_msg_sel;
               w_sb       = bus.i_sb;
               w_busy     = 1'b1;
               w_send     = 1'b1;
            end
         end
         S_START: begin
            w_state   = S_DATA;
            w_bit_cnt = '0;
            w_out     = r_msg[0];
         end
         S_DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_state   = S_GAP;
               w_bit_cnt = '0;
               w_gap_cnt = '0;
            end else begin
               w_bit_cnt = r_bit_cnt + BIT_W'(1);
               w_out     = r_msg[w_bit_cnt];
            end
         end
         S_GAP: begin
            if (r_gap_cnt == r_sb) begin
               w_state   = S_IDLE;
               w_busy    = 1'b0;
               w_gap_cnt = '0;
            end else begin
               w_gap_cnt = r_gap_cnt + SB_W'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_ack      <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_send     <= 1'b0;
         r_out      <= 1'b0;
         r_msg      <= '0;
         r_sb       <= '0;
         r_rr       <= RR_INIT;
         r_bit_cnt  <= '0;
         r_gap_cnt  <= '0;
      end else begin
         r_state    <= w_state;
         r_ack      <= w_ack;
         r_grant_id <= w_grant_id;
         r_busy     <= w_busy;
         r_send     <= w_send;
         r_out      <= w_out;
         r_msg      <= w_msg;
         r_sb       <= w_sb;
         r_rr       <= w_rr;
         r_bit_cnt  <= w_bit_cnt;
         r_gap_cnt  <= w_gap_cnt;
      end
   end

   assign bus.o_ack      = r_ack;
   assign bus.o_grant_id = r_grant_id;
   assign bus.o_busy     = r_busy;
   assign bus.o_send     = r_send;
   assign bus.o_out      = r_out;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench for serial_tx_scheduler. At every clock edge the model
// decides, from the inputs it just drove, what the line must show in the
// following cycles and queues those cycles; a monitor pops one entry per
// cycle and compares it with the DUT outputs.
module tb_serial_tx_scheduler;
   localparam int N_REQ   = 4;
   localparam int MSG_W   = 4;
   localparam int SB_W    = 4;
   localparam int GRANT_W = 2;

   typedef struct packed {
      logic [N_REQ-1:0]   ack;
      logic [GRANT_W-1:0] gid;
      logic               busy;
      logic               send;
      logic               out;
   } line_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_tx_if #(.N_REQ(N_REQ), .MSG_W(MSG_W), .SB_W(SB_W)) bus ();

   serial_tx_scheduler #(.N_REQ(N_REQ), .MSG_W(MSG_W), .SB_W(SB_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   line_t exp_q[$];
   int    rr;
   int    gid;
   int    busy_left;
   bit    started = 1'b0;
   bit    done    = 1'b0;
   int    cyc     = 0;
   int    n_checks = 0;
   int    n_errors = 0;

   // Reference model: a grant schedules a complete frame as a list of line
   // cycles; otherwise one idle cycle is scheduled.
   function automatic void model_edge();
      line_t                  e;
      int                     w;
      int                     c;
      int                     sbv;
      logic [N_REQ-1:0]       rq;
      logic [N_REQ*MSG_W-1:0] sh;
      logic [MSG_W-1:0]       m;
      logic [MSG_W-1:0]       mb;
      if (rst) begin
         exp_q.delete();
         rr        = N_REQ - 1;
         gid       = 0;
         busy_left = 0;
         e         = '0;
         exp_q.push_back(e);
         started   = 1'b1;
         return;
      end
      if (busy_left == 0) begin
         rq = bus.i_req;
         if (bus.i_en && rq != '0) begin
            w = -1;
            for (int k = 1; k <= N_REQ; k++) begin
               c = (rr + k) % N_REQ;
               if (w < 0 && ((rq >> c) & N_REQ'(1)) != '0) w = c;
            end
            rr  = w;
            gid = w;
            sh  = bus.i_msg >> (w * MSG_W);
            m   = sh[MSG_W-1:0];
            sbv = int'(bus.i_sb);
            e.ack  = N_REQ'(1) << w;
            e.gid  = GRANT_W'(gid);
            e.busy = 1'b1;
            e.send = 1'b1;
            e.out  = 1'b0;
            exp_q.push_back(e);
            e.ack  = '0;
            e.send = 1'b0;
            for (int b = 0; b < MSG_W; b++) begin
               mb    = m >> b;
               e.out = mb[0];
               exp_q.push_back(e);
            end
            e.out = 1'b0;
            for (int g = 0; g <= sbv; g++) exp_q.push_back(e);
            e.busy = 1'b0;
            exp_q.push_back(e);
            busy_left = 1 + MSG_W + sbv + 1 + 1;
         end else begin
            e      = '0;
            e.gid  = GRANT_W'(gid);
            exp_q.push_back(e);
            busy_left = 1;
         end
      end
      busy_left--;
   endfunction

   // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
   initial begin
      line_t ex;
      line_t act;
      forever begin
         @(negedge clk);
         cyc++;
         if (started && !done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL scoreboard_empty cycle=%0d: no expected entry for DUT output", cyc);
            end else begin
               ex       = exp_q.pop_front();
               act.ack  = bus.o_ack;
               act.gid  = bus.o_grant_id;
               act.busy = bus.o_busy;
               act.send = bus.o_send;
               act.out  = bus.o_out;
               if (act !== ex) begin
                  n_errors++;
                  $display("FAIL line cycle=%0d got ack=%b gid=%0d busy=%b send=%b out=%b need ack=%b gid=%0d busy=%b send=%b out=%b",
                           cyc, act.ack, act.gid, act.busy, act.send, act.out,
                           ex.ack, ex.gid, ex.busy, ex.send, ex.out);
               end
            end
         end
      end
   end

   task automatic drive(input logic r, input logic e, input logic [N_REQ-1:0] rq,
                        input logic [N_REQ*MSG_W-1:0] m, input logic [SB_W-1:0] s);
      rst        = r;
      bus.i_en   = e;
      bus.i_req  = rq;
      bus.i_msg  = m;
      bus.i_sb   = s;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, '0, '0, '0);
      step(2);

      // single requester 0, MSG0=1011, SB=2
      drive(1'b0, 1'b1, 4'b0001, 16'h000B, 4'd2);
      step(3);
      drive(1'b0, 1'b1, 4'b0000, 16'h000B, 4'd2);
      step(12);

      // all requesting, SB=0: rotating grants 7 cycles apart
      drive(1'b0, 1'b1, 4'b1111, 16'h4C7A, 4'd0);
      step(40);

      // EN dropped and MSG/SB changed in the middle of a frame
      drive(1'b0, 1'b1, 4'b0000, 16'h0000, 4'd0);
      step(10);
      drive(1'b0, 1'b1, 4'b0010, 16'h00A0, 4'd3);
      step(3);
      drive(1'b0, 1'b0, 4'b0110, 16'h0F50, 4'd9);
      step(20);
      drive(1'b0, 1'b1, 4'b0110, 16'h0F50, 4'd1);
      step(15);

      // reset during the second data cycle
      drive(1'b1, 1'b1, 4'b1111, 16'h5555, 4'd1);
      step(1);
      drive(1'b0, 1'b1, 4'b1110, 16'h9365, 4'd1);
      step(3);
      drive(1'b1, 1'b1, 4'b1110, 16'h9365, 4'd1);
      step(1);
      drive(1'b0, 1'b1, 4'b1100, 16'h9365, 4'd1);
      step(20);

      // one-cycle pulse on REQ0
      drive(1'b1, 1'b1, 4'b0000, 16'h0000, 4'd0);
      step(1);
      drive(1'b0, 1'b1, 4'b0001, 16'h0006, 4'd0);
      step(1);
      drive(1'b0, 1'b1, 4'b0000, 16'h0009, 4'd0);
      step(20);

      // maximum gap, two requesters held
      drive(1'b0, 1'b1, 4'b0101, 16'h3E2D, 4'd15);
      step(50);

      // randomized traffic with rare resets and EN drops
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 7) != 0),
               N_REQ'($urandom),
               16'($urandom),
               ($urandom_range(0, 9) == 0) ? 4'd15 : SB_W'($urandom_range(0, 4)));
         step(1);
      end

      @(posedge clk);
      done = 1'b1;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
